// File: rtl/rf_wr_arb.sv
// rf_wr_arb: shares the register-file write port between pipeline writeback
// and a late-returning multi-cycle unit. Late results that lose the port are
// held in a small circular FIFO. A pending-write bitmap drives the decode stall.
module rf_wr_arb #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            core_we,
  input  logic [4:0]      core_rd,
  input  logic [XLEN-1:0] core_data,
  input  logic            mc_issue,
  input  logic [4:0]      mc_issue_rd,
  input  logic            mc_valid,
  input  logic [4:0]      mc_rd,
  input  logic [XLEN-1:0] mc_data,
  output logic            mc_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_data,
  output logic            stall,
  output logic [31:0]     busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [4:0]      mem_rd   [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     busy_q, busy_nxt, set_vec, clr_vec;
  logic            core_eff, empty, full, pop, bypass, push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Port arbitration, FIFO handshake, scoreboard update and stall decode.
  always_comb begin
    core_eff = core_we && (core_rd != 5'd0);
    empty    = (count == '0);
    full     = (count == FULL_CNT);
    pop      = !reset && !core_eff && !empty;
    bypass   = !reset && !core_eff && empty && mc_valid && (mc_rd != 5'd0);
    // ready depends on registered fullness only, so a same-cycle pop never raises it
    mc_ready = !reset && !full;
    push     = mc_valid && mc_ready && (mc_rd != 5'd0) && !bypass;

    rf_we   = 1'b0;
    rf_rd   = 5'd0;
    rf_data = '0;
    if (core_eff && !reset) begin
      rf_we   = 1'b1;
      rf_rd   = core_rd;
      rf_data = core_data;
    end else if (pop) begin
      rf_we   = 1'b1;
      rf_rd   = mem_rd[rd_ptr];
      rf_data = mem_data[rd_ptr];
    end else if (bypass) begin
      rf_we   = 1'b1;
      rf_rd   = mc_rd;
      rf_data = mc_data;
    end

    clr_vec = '0;
    if (pop || bypass) clr_vec[rf_rd] = 1'b1;
    set_vec = '0;
    if (mc_issue && (mc_issue_rd != 5'd0)) set_vec[mc_issue_rd] = 1'b1;
    // a new issue owns the register, so set overrides a same-cycle clear
    busy_nxt    = (busy_q & ~clr_vec) | set_vec;
    busy_nxt[0] = 1'b0;

    stall = !reset && (busy_q[rs1] || busy_q[rs2] ||
                       (core_eff && busy_q[core_rd]) ||
                       (mc_issue && busy_q[mc_issue_rd]));
    busy  = busy_q;
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr]   <= mc_rd;
      mem_data[wr_ptr] <= mc_data;
    end
  end

  // Pointers, occupancy and pending-write bitmap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      busy_q <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      busy_q <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_rf_wr_arb.sv
// tb_rf_wr_arb: directed scenarios plus random traffic against a queue-based
// reference model; expected RF writes are scoreboarded and checked by a monitor.
module tb_rf_wr_arb;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            core_we;
  logic [4:0]      core_rd;
  logic [XLEN-1:0] core_data;
  logic            mc_issue;
  logic [4:0]      mc_issue_rd;
  logic            mc_valid;
  logic [4:0]      mc_rd;
  logic [XLEN-1:0] mc_data;
  logic            mc_ready;
  logic [4:0]      rs1, rs2;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_data;
  logic            stall;
  logic [31:0]     busy;

  rf_wr_arb #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .core_we(core_we), .core_rd(core_rd), .core_data(core_data),
    .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
    .rs1(rs1), .rs2(rs2),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
    .stall(stall), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [XLEN-1:0] data; } res_t;
  typedef struct { int cyc; logic [4:0] rd; logic [XLEN-1:0] data; } wr_t;

  res_t        m_q[$];
  logic [31:0] m_busy;
  wr_t         exp_q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic [XLEN-1:0] d);
    wr_t e;
    e.cyc = cyc; e.rd = rd; e.data = d;
    exp_q.push_back(e);
  endtask

  // Reference model: the FIFO is a queue, the scoreboard a 32-bit set.
  task automatic model_step();
    res_t r;
    logic ce, rdy_e, stall_e, bypassed;
    if (reset) begin
      chk("stall_in_reset", {31'd0, stall}, 32'd0);
      chk("ready_in_reset", {31'd0, mc_ready}, 32'd0);
      m_q.delete();
      m_busy = '0;
      return;
    end
    rdy_e   = (m_q.size() < DEPTH);
    ce      = core_we && (core_rd != 0);
    stall_e = m_busy[rs1] || m_busy[rs2] || (ce && m_busy[core_rd]) ||
              (mc_issue && m_busy[mc_issue_rd]);
    chk("stall", {31'd0, stall}, {31'd0, stall_e});
    chk("mc_ready", {31'd0, mc_ready}, {31'd0, rdy_e});
    chk("busy", busy, m_busy);
    bypassed = 1'b0;
    if (ce) begin
      push_exp(core_rd, core_data);
    end else if (m_q.size() > 0) begin
      r = m_q.pop_front();
      push_exp(r.rd, r.data);
      m_busy[r.rd] = 1'b0;
    end else if (mc_valid && mc_rd != 0) begin
      push_exp(mc_rd, mc_data);
      m_busy[mc_rd] = 1'b0;
      bypassed = 1'b1;
    end
    if (mc_valid && rdy_e && mc_rd != 0 && !bypassed) begin
      r.rd = mc_rd; r.data = mc_data;
      m_q.push_back(r);
    end
    if (mc_issue && mc_issue_rd != 0) m_busy[mc_issue_rd] = 1'b1;
  endtask

  // Inputs are held from just after one posedge to just after the next.
  task automatic tick();
    @(negedge clk);
    cyc++;
    #1 model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; core_we = 0; core_rd = 0; core_data = 0;
    mc_issue = 0; mc_issue_rd = 0; mc_valid = 0; mc_rd = 0; mc_data = 0;
    rs1 = 0; rs2 = 0;
  endtask

  task automatic core(input logic [4:0] rd, input logic [31:0] d);
    core_we = 1; core_rd = rd; core_data = d;
  endtask

  task automatic result(input logic [4:0] rd, input logic [31:0] d);
    mc_valid = 1; mc_rd = rd; mc_data = d;
  endtask

  task automatic issue(input logic [4:0] rd);
    mc_issue = 1; mc_issue_rd = rd;
  endtask

  // Monitor: every DUT write must match the oldest expected write, same cycle.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write cyc=%0d got rd=%0d data=%h want none", cyc, rf_rd, rf_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_rd", {27'd0, rf_rd}, {27'd0, e.rd});
          chk("wr_data", rf_data, e.data);
        end
      end
    end
  end

  initial begin
    idle();
    reset = 1;
    tick(); tick();

    // bypass of a result straight to the port, and RAW stall around it
    idle(); issue(5); tick();
    idle(); rs1 = 5; tick();
    idle(); result(5, 32'hDEAD); tick();
    idle(); rs1 = 5; tick();

    // results queue behind core writes; third one is refused when full
    idle(); core(3, 32'h33); result(8, 1); tick();
    idle(); core(3, 32'h34); result(9, 2); tick();
    idle(); core(3, 32'h35); result(10, 3); tick();
    idle(); tick();
    idle(); tick();

    // a write to x0 leaves the port to the FIFO head
    idle(); core(3, 32'h36); result(4, 32'h55); tick();
    idle(); core(0, 32'h99); tick();

    // set wins over clear on the same register
    idle(); issue(6); tick();
    idle(); result(6, 32'h66); issue(6); tick();
    idle(); issue(6); tick();
    idle(); result(6, 32'h67); tick();
    idle(); tick();

    // wrap: push/pop pairs interleaved with core writes
    for (int i = 0; i < 6; i++) begin
      idle(); core(2, i); result(5'(11 + i), 32'h100 + i); tick();
      idle(); result(5'(17 + i), 32'h200 + i); tick();
    end
    idle(); tick(); tick(); tick();

    // reset mid-drain with a full FIFO and busy x5, x7
    idle(); issue(5); tick();
    idle(); issue(7); core(1, 1); result(12, 32'hA); tick();
    idle(); core(1, 2); result(13, 32'hB); tick();
    idle(); reset = 1; tick();
    idle(); tick(); tick(); tick();

    // random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      idle();
      reset       = ($urandom_range(0, 99) == 0);
      core_we     = ($urandom_range(0, 2) == 0);
      core_rd     = 5'($urandom_range(0, 7));
      core_data   = $urandom;
      mc_issue    = ($urandom_range(0, 3) == 0);
      mc_issue_rd = 5'($urandom_range(0, 7));
      mc_valid    = ($urandom_range(0, 1) == 0);
      mc_rd       = 5'($urandom_range(0, 7));
      mc_data     = $urandom;
      rs1         = 5'($urandom_range(0, 9));
      rs2         = 5'($urandom_range(0, 9));
      tick();
    end
    idle(); tick(); tick(); tick();
    @(negedge clk);
    #3;
    chk("writes_outstanding", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wr_arb.md
# rf_wr_arb

Register-file write-port arbiter and scoreboard for the core. Shares the single register-file write port between the in-order pipeline writeback and a multi-cycle execution unit (divider/load unit) that returns results late. Buffers late results in a small FIFO and tracks pending destination registers. Raises a stall when the pipeline would read or overwrite a register whose result is still outstanding. Sits between writeback, the multi-cycle unit and the register file, upstream of the write-through select logic.

## Interface
- `DEPTH`, 2: result FIFO entries; power of two, ≥1.
- `XLEN`, 32: data width.
- `clk` in 1: core clock.
- `reset` in 1: synchronous, active-high.
- `core_we` in 1: pipeline writeback enable.
- `core_rd` in 5: pipeline writeback destination.
- `core_data` in XLEN: pipeline writeback data.
- `mc_issue` in 1: multi-cycle op accepted this cycle; claims `mc_issue_rd`.
- `mc_issue_rd` in 5: destination of issued multi-cycle op.
- `mc_valid` in 1: multi-cycle result available.
- `mc_rd` in 5: result destination.
- `mc_data` in XLEN: result data.
- `mc_ready` out 1: result accepted when `mc_valid && mc_ready`.
- `rs1`, `rs2` in 5: source registers of the instruction in decode.
- `rf_we` out 1: register-file write enable.
- `rf_rd` out 5: register-file write address.
- `rf_data` out XLEN: register-file write data.
- `stall` out 1: hold decode/issue this cycle.
- `busy` out 32: pending-write bitmap; bit 0 is always 0.

## Operation
- Effective core write: `core_we && core_rd != 0`. A write to x0 counts as no write and frees the port.
- Port priority, evaluated combinationally each cycle:
  1. Effective core write drives `rf_we=1`, `rf_rd=core_rd`, `rf_data=core_data`.
  2. Otherwise, if the FIFO is non-empty, pop the head to the port.
  3. Otherwise, if `mc_valid` is high, bypass the result straight to the port; it is not enqueued.
  4. Otherwise `rf_we=0`, `rf_rd=0`, `rf_data=0`.
- Enqueue: `mc_valid && mc_ready`, and the result is not bypassed.
- `mc_ready = !full`. When the FIFO is empty, `mc_ready=1` regardless of the core write.
- Full case: a same-cycle pop does not raise `mc_ready`; no combinational pop-to-ready path.
- Results with `mc_rd == 0` are accepted and discarded: never enqueued, never written.
- Scoreboard set: `mc_issue && mc_issue_rd != 0` sets `busy[mc_issue_rd]`.
- Scoreboard clear: writing a multi-cycle result to the RF (pop or bypass) clears `busy[rf_rd]`. A core write never clears busy.
- Set and clear of the same register in one cycle: set wins, because a new op owns it.
- `stall` is combinational and is high when any of these holds:
  - `busy[rs1]` or `busy[rs2]` (RAW);
  - effective core write with `busy[core_rd]` (WAW);
  - `mc_issue` with `busy[mc_issue_rd]` (second outstanding op to the same register).
- `stall` does not gate any input. If the core writes while stalled, the write still takes the port and busy is unchanged. Upstream must honour `stall`.
- FIFO is a circular buffer. Read and write pointers wrap modulo `DEPTH`; a count or extra pointer bit distinguishes full from empty.
- Simultaneous push and pop when not full or empty: count is unchanged and both occur.

## Timing
- Port select and `stall` are combinational; the register-file write commits at the next `clk` rising edge.
- Result latency to the RF:
  - 0 cycles when bypassed;
  - otherwise written in the first cycle with no effective core write and the entry at the FIFO head. Order is FIFO.
- Worst-case drain of N queued results: N cycles with no core writes.
- A busy bit set at edge t is visible on `stall` during cycle t+1.
- A clear committed at edge t removes the stall in cycle t+1. There is no same-cycle un-stall from a result being written; forwarding of that value is handled by the write-through logic.
- Reset (synchronous, any cycle, including mid-drain):
  - FIFO empties, pointers and count go to 0, `busy` goes to 0.
  - Queued results are discarded.
  - While `reset` is high: `rf_we=0`, `rf_rd=0`, `rf_data=0`, `stall=0`, `mc_ready=0`.
  - After release: `mc_ready=1`.

## Test plan
- Reset with 2 queued entries and busy={x5,x7} -> after one reset cycle: `busy=0`, `mc_ready=1`, `rf_we=0`, no queued writes ever appear.
- Issue x5, next cycle `rs1=5` -> `stall=1`. Result x5=0xDEAD with no core write -> `rf_we=1`, `rf_rd=5`, `rf_data=0xDEAD` same cycle. Following cycle `busy[5]=0`, `stall=0`.
- Core writes x3 every cycle while results x8=1, x9=2 arrive -> both enqueued, third result sees `mc_ready=0`. First idle cycle writes x8, next idle cycle writes x9, in that order.
- `core_we=1`, `core_rd=0` with head entry x4=0x55 -> RF writes x4=0x55; the x0 write is dropped.
- Result x6 written in the same cycle as a new `mc_issue` to x6 -> `busy[6]=1` after the edge. `mc_issue` to busy x6 -> `stall=1`.
- `DEPTH=2` wrap: 6 push/pop pairs interleaved with core writes -> data order is preserved, and full/empty are reported correctly at every step.
